// File: rtl/lfclk_gen.sv
// -----------------------------------------------------------------------------
// lfclk_gen -- multi-channel programmable low-frequency clock generator.
//
// Each channel divides clk_8388 by a runtime-loadable ratio and produces a
// registered 50%-ish duty clock (odd ratios give the extra cycle to the high
// phase) plus a one-cycle tick in the cycle the clock rises. Ratio changes
// are staged in a pending register and applied only at a period boundary or
// while idle, so the output never shows a runt phase. All channels are held
// idle while the synchronised MMCM lock is low.
//
// Ports:
//   clk_8388     in   8.388 MHz clock
//   ck_rst       in   asynchronous active-low reset
//   mmcm_locked  in   MMCM lock, asynchronous to clk_8388
//   ch_en        in   [NCH]        per-channel run request (level)
//   div_val      in   [NCH*CNT_W]  requested ratio, channel i at [i*CNT_W +: CNT_W]
//   div_load     in   [NCH]        one-cycle pulse, captures div_val of that channel
//   clk_out      out  [NCH]        divided clock (registered)
//   tick         out  [NCH]        one-cycle pulse when clk_out rises
//   div_busy     out  [NCH]        captured ratio not yet applied
// -----------------------------------------------------------------------------
module lfclk_gen #(
    parameter int NCH     = 2,
    parameter int CNT_W   = 16,
    parameter int DIV_RST = 256
) (
    input  logic                   clk_8388,
    input  logic                   ck_rst,
    input  logic                   mmcm_locked,
    input  logic [NCH-1:0]         ch_en,
    input  logic [NCH*CNT_W-1:0]   div_val,
    input  logic [NCH-1:0]         div_load,
    output logic [NCH-1:0]         clk_out,
    output logic [NCH-1:0]         tick,
    output logic [NCH-1:0]         div_busy
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] DIV_RST_V = CNT_W'(DIV_RST);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO       = CNT_W'(2);

    // Ratios below 2 cannot produce a clock; store them as 2.
    function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] v);
        return (v < TWO) ? TWO : v;
    endfunction

    // Two-flop synchroniser for the asynchronous MMCM lock.
    logic r_lock_m;
    logic r_lock_s;

    always_ff @(posedge clk_8388 or negedge ck_rst) begin
        if (!ck_rst) begin
            r_lock_m <= 1'b0;
            r_lock_s <= 1'b0;
        end else begin
            r_lock_m <= mmcm_locked;
            r_lock_s <= r_lock_m;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        state_t           r_state, w_state_nx;
        logic [CNT_W-1:0] r_cnt, w_cnt_nx;
        logic [CNT_W-1:0] r_act, w_act_nx;
        logic [CNT_W-1:0] r_pend, w_pend_nx;
        logic             r_busy, w_busy_nx;
        logic             r_clk, w_clk_nx;
        logic             r_tick, w_tick_nx;
        logic             w_apply;
        logic             w_term;
        logic [CNT_W:0]   w_half;

        // Terminal count; div_act is never below 2 so this cannot underflow.
        assign w_term = (r_cnt == (r_act - ONE));

        always_comb begin
            w_state_nx = r_state;
            w_cnt_nx   = r_cnt;
            w_act_nx   = r_act;
            w_pend_nx  = r_pend;
            w_busy_nx  = r_busy;
            w_tick_nx  = 1'b0;
            w_apply    = 1'b0;
            w_clk_nx   = 1'b0;
            w_half     = '0;

            if (!r_lock_s) begin
                w_state_nx = ST_IDLE;
                w_cnt_nx   = '0;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        w_apply = r_busy;
                        if (ch_en[g]) begin
                            w_state_nx = ST_RUN;
                            w_cnt_nx   = '0;
                            w_tick_nx  = 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (!w_term) begin
                            w_cnt_nx = r_cnt + ONE;
                        end else if (ch_en[g]) begin
                            w_cnt_nx  = '0;
                            w_tick_nx = 1'b1;
                            w_apply   = r_busy;
                        end else begin
                            w_state_nx = ST_IDLE;
                            w_cnt_nx   = '0;
                        end
                    end
                endcase
            end

            // A same-cycle load supersedes the apply: the fresh value stays
            // pending and is taken at the next boundary.
            if (w_apply && !div_load[g]) begin
                w_act_nx  = r_pend;
                w_busy_nx = 1'b0;
            end
            if (div_load[g]) begin
                w_pend_nx = clamp_div(div_val[g*CNT_W +: CNT_W]);
                w_busy_nx = 1'b1;
            end

            // High phase length, one bit wider so a ratio of 2^CNT_W-1 does
            // not wrap.
            w_half   = ({1'b0, w_act_nx} + {{CNT_W{1'b0}}, 1'b1}) >> 1;
            w_clk_nx = (w_state_nx == ST_RUN) && ({1'b0, w_cnt_nx} < w_half);
        end

        always_ff @(posedge clk_8388 or negedge ck_rst) begin
            if (!ck_rst) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_act   <= DIV_RST_V;
                r_pend  <= DIV_RST_V;
                r_busy  <= 1'b0;
                r_clk   <= 1'b0;
                r_tick  <= 1'b0;
            end else begin
                r_state <= w_state_nx;
                r_cnt   <= w_cnt_nx;
                r_act   <= w_act_nx;
                r_pend  <= w_pend_nx;
                r_busy  <= w_busy_nx;
                r_clk   <= w_clk_nx;
                r_tick  <= w_tick_nx;
            end
        end

        assign clk_out[g]  = r_clk;
        assign tick[g]     = r_tick;
        assign div_busy[g] = r_busy;
    end

endmodule

// File: tb/tb_lfclk_gen.sv
// -----------------------------------------------------------------------------
// tb_lfclk_gen -- self-checking bench for lfclk_gen.
// A period-level reference model (period start time + ratio per channel)
// predicts clk_out/tick/div_busy every cycle; a few directed measurements
// pin the model with hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_lfclk_gen;

    localparam int NCH     = 2;
    localparam int CNT_W   = 16;
    localparam int DIV_RST = 256;

    logic                 clk_8388 = 1'b0;
    logic                 ck_rst;
    logic                 mmcm_locked;
    logic [NCH-1:0]       ch_en;
    logic [NCH*CNT_W-1:0] div_val;
    logic [NCH-1:0]       div_load;
    logic [NCH-1:0]       clk_out;
    logic [NCH-1:0]       tick;
    logic [NCH-1:0]       div_busy;

    int total = 0;
    int bad   = 0;

    always #60 clk_8388 = ~clk_8388;

    lfclk_gen #(
        .NCH     (NCH),
        .CNT_W   (CNT_W),
        .DIV_RST (DIV_RST)
    ) dut (
        .clk_8388    (clk_8388),
        .ck_rst      (ck_rst),
        .mmcm_locked (mmcm_locked),
        .ch_en       (ch_en),
        .div_val     (div_val),
        .div_load    (div_load),
        .clk_out     (clk_out),
        .tick        (tick),
        .div_busy    (div_busy)
    );

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int             cyc;
    bit             lk_m, lk_s;
    bit             m_on   [NCH];
    int             m_t0   [NCH];
    int             m_act  [NCH];
    int             m_pend [NCH];
    bit             m_busy [NCH];
    logic [NCH-1:0] e_clk, e_tick, e_busy;
    bit             chk_en = 1'b0;

    task automatic model_reset();
        cyc  = 0;
        lk_m = 1'b0;
        lk_s = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            m_on[c]   = 1'b0;
            m_t0[c]   = 0;
            m_act[c]  = DIV_RST;
            m_pend[c] = DIV_RST;
            m_busy[c] = 1'b0;
        end
        e_clk  = '0;
        e_tick = '0;
        e_busy = '0;
    endtask

    // Advance the model by one clock edge using the inputs present at the edge.
    task automatic model_step();
        bit ls;
        ls   = lk_s;
        lk_s = lk_m;
        lk_m = mmcm_locked;
        for (int c = 0; c < NCH; c++) begin
            int v;
            bit ld;
            v  = int'(div_val[c*CNT_W +: CNT_W]);
            ld = div_load[c];
            if (v < 2) v = 2;
            if (!ls) begin
                m_on[c] = 1'b0;
            end else if (!m_on[c]) begin
                if (m_busy[c] && !ld) begin
                    m_act[c]  = m_pend[c];
                    m_busy[c] = 1'b0;
                end
                if (ch_en[c]) begin
                    m_on[c] = 1'b1;
                    m_t0[c] = cyc + 1;
                end
            end else if (cyc - m_t0[c] == m_act[c] - 1) begin
                if (ch_en[c]) begin
                    m_t0[c] = cyc + 1;
                    if (m_busy[c] && !ld) begin
                        m_act[c]  = m_pend[c];
                        m_busy[c] = 1'b0;
                    end
                end else begin
                    m_on[c] = 1'b0;
                end
            end
            if (ld) begin
                m_pend[c] = v;
                m_busy[c] = 1'b1;
            end
        end
        cyc++;
        for (int c = 0; c < NCH; c++) begin
            e_clk[c]  = m_on[c] && (2 * (cyc - m_t0[c]) < m_act[c]);
            e_tick[c] = m_on[c] && (cyc == m_t0[c]);
            e_busy[c] = m_busy[c];
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk_8388) begin
        if (chk_en) begin
            for (int c = 0; c < NCH; c++) begin
                check($sformatf("clk_out[%0d]", c), 32'(clk_out[c]), 32'(e_clk[c]));
                check($sformatf("tick[%0d]", c), 32'(tick[c]), 32'(e_tick[c]));
                check($sformatf("div_busy[%0d]", c), 32'(div_busy[c]), 32'(e_busy[c]));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc_step();
        @(posedge clk_8388);
        model_step();
        @(negedge clk_8388);
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) cyc_step();
    endtask

    // From the next tick, count one full period and its high cycles.
    task automatic measure(input int ch, output int hi, output int per);
        int n;
        hi  = 0;
        per = 0;
        n   = 0;
        while (!tick[ch] && n < 2000) begin
            cyc_step();
            n++;
        end
        if (n >= 2000) begin
            check($sformatf("tick_wait[%0d]", ch), 0, 1);
            return;
        end
        do begin
            if (clk_out[ch]) hi++;
            per++;
            cyc_step();
        end while (!tick[ch] && per < 2000);
    endtask

    task automatic load(input int ch, input int val);
        div_val[ch*CNT_W +: CNT_W] = CNT_W'(val);
        div_load[ch] = 1'b1;
        cyc_step();
        div_load[ch] = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int hi, per;
        ck_rst      = 1'b0;
        mmcm_locked = 1'b1;
        ch_en       = '0;
        div_val     = '0;
        div_load    = '0;
        repeat (3) @(negedge clk_8388);
        check("rst_clk_out", 32'(clk_out), 0);
        check("rst_tick", 32'(tick), 0);
        check("rst_div_busy", 32'(div_busy), 0);

        model_reset();
        chk_en = 1'b1;
        ch_en  = 2'b01;
        ck_rst = 1'b1;

        // Default ratio on channel 0.
        measure(0, hi, per);
        check("ch0_256_high", hi, 128);
        check("ch0_256_period", per, 256);

        // Channel 1 ratio 5 loaded while idle.
        load(1, 5);
        check("ch1_busy_set", 32'(div_busy[1]), 1);
        cyc_step();
        check("ch1_busy_clr", 32'(div_busy[1]), 0);
        ch_en[1] = 1'b1;
        cyc_step();
        check("ch1_first_tick", 32'(tick[1]), 1);
        measure(1, hi, per);
        check("ch1_5_high", hi, 3);
        check("ch1_5_period", per, 5);

        // Reload channel 0 mid-period (cnt=50).
        measure(0, hi, per);
        step_n(50);
        load(0, 10);
        check("ch0_busy_mid", 32'(div_busy[0]), 1);
        measure(0, hi, per);
        check("ch0_10_high", hi, 5);
        check("ch0_10_period", per, 10);

        // Drop ch_en in the high phase; period completes then stays idle.
        step_n(2);
        ch_en[0] = 1'b0;
        step_n(20);
        check("ch0_idle", 32'(clk_out[0]), 0);
        ch_en[0] = 1'b1;
        cyc_step();
        check("ch0_restart_tick", 32'(tick[0]), 1);
        check("ch0_restart_clk", 32'(clk_out[0]), 1);

        // Lock loss and relock.
        step_n(3);
        mmcm_locked = 1'b0;
        step_n(3);
        check("unlock_clk_out", 32'(clk_out), 0);
        step_n(4);
        mmcm_locked = 1'b1;
        cyc_step();
        check("relock_tick_c1", 32'(tick), 0);
        cyc_step();
        check("relock_tick_c2", 32'(tick), 0);
        cyc_step();
        check("relock_tick_c3", 32'(tick), 32'h3);
        check("relock_clk_c3", 32'(clk_out), 32'h3);
        measure(1, hi, per);
        check("ch1_retained_period", per, 5);

        // div_val=0 clamps to 2.
        cyc_step();
        load(1, 0);
        measure(1, hi, per);
        check("ch1_clamp_high", hi, 1);
        check("ch1_clamp_period", per, 2);

        // Load on the terminal cycle: busy stays set, applies a period later.
        cyc_step();
        load(1, 6);
        check("ch1_busy_term", 32'(div_busy[1]), 1);
        measure(1, hi, per);
        check("ch1_term_old_period", per, 2);
        measure(1, hi, per);
        check("ch1_term_new_high", hi, 3);
        check("ch1_term_new_period", per, 6);

        // Randomised traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 19) == 0) ch_en[c] = ~ch_en[c];
                div_load[c] = ($urandom_range(0, 29) == 0);
                div_val[c*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 12));
            end
            if ($urandom_range(0, 299) == 0) mmcm_locked = ~mmcm_locked;
            cyc_step();
        end
        div_load = '0;
        step_n(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
